// File: rtl/sprite_sequencer.sv
// Memory-game sequencer: grows an LFSR quadrant pattern, plays it back per frame, checks presses.
// Optional build macro SPRITE_SEQ_ECHO_EN: echo each correct non-final press on screen.
module sprite_sequencer #(
  parameter int unsigned SEQ_LEN     = 8,
  parameter int unsigned SHOW_FRAMES = 30,
  parameter int unsigned GAP_FRAMES  = 15,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       btn_valid,
  input  logic [2:0] btn_quad,
  output logic [3:0] step,
  output logic [2:0] cuadrante,
  output logic [3:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_SHOW, S_GAP, S_INPUT, S_LOSE, S_WIN, S_ECHO
  } state_t;

  localparam logic [7:0] SHOW_LAST = 8'(SHOW_FRAMES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_FRAMES - 1);
  localparam logic [3:0] LEN_MAX   = 4'(SEQ_LEN);

  state_t     r_state, w_state_nx;
  logic [7:0] r_lfsr, w_lfsr_nx;
  logic [2:0] r_seq [0:15];
  logic [3:0] r_level, w_lvl_nx;
  logic [3:0] r_idx, w_idx_nx, w_idx_inc;
  logic [7:0] r_frm, w_frm_nx;
  logic [2:0] r_echo_q, w_echo_nx;
  logic       w_wr_en, w_btn_ok;
  logic [2:0] w_new_q, w_show_q;
  logic [3:0] r_step, w_step_nx;
  logic [2:0] r_cuad, w_cuad_nx;
  logic       r_busy, w_busy_nx, r_win, w_win_nx, r_lose, w_lose_nx;

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
  assign w_lfsr_nx = r_lfsr[0] ? ({1'b0, r_lfsr[7:1]} ^ 8'hB8) : {1'b0, r_lfsr[7:1]};
  assign w_new_q   = {1'b0, r_lfsr[1:0]} + 3'd1;
  assign w_btn_ok  = btn_valid && (btn_quad >= 3'd1) && (btn_quad <= 3'd4);
  assign w_idx_inc = r_idx + 4'd1;

  // Next-state, index, level and frame-counter logic
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_lvl_nx   = r_level;
    w_frm_nx   = r_frm;
    w_echo_nx  = r_echo_q;
    w_wr_en    = 1'b0;
    case (r_state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          w_state_nx = S_GEN;
          w_lvl_nx   = 4'd0;
        end else begin
          w_state_nx = r_state;
        end
      end
      S_GEN: begin
        w_wr_en    = 1'b1;
        w_lvl_nx   = r_level + 4'd1;
        w_idx_nx   = 4'd0;
        w_frm_nx   = 8'd0;
        w_state_nx = S_SHOW;
      end
      S_SHOW, S_ECHO: begin
        if (frame_tick && (r_frm == SHOW_LAST)) begin
          w_frm_nx   = 8'd0;
          w_state_nx = (r_state == S_SHOW) ? S_GAP : S_INPUT;
        end else if (frame_tick) begin
          w_frm_nx = r_frm + 8'd1;
        end else begin
          w_frm_nx = r_frm;
        end
      end
      S_GAP: begin
        if (frame_tick && (r_frm == GAP_LAST)) begin
          w_frm_nx = 8'd0;
          if (w_idx_inc == r_level) begin
            w_state_nx = S_INPUT;
            w_idx_nx   = 4'd0;
          end else begin
            w_state_nx = S_SHOW;
            w_idx_nx   = w_idx_inc;
          end
        end else if (frame_tick) begin
          w_frm_nx = r_frm + 8'd1;
        end else begin
          w_frm_nx = r_frm;
        end
      end
      S_INPUT: begin
        if (!w_btn_ok) begin
          w_state_nx = S_INPUT;
        end else if (btn_quad != r_seq[r_idx]) begin
          w_state_nx = S_LOSE;
        end else if (w_idx_inc < r_level) begin
          w_idx_nx = w_idx_inc;
`ifdef SPRITE_SEQ_ECHO_EN
          w_state_nx = S_ECHO;
          w_echo_nx  = btn_quad;
          w_frm_nx   = 8'd0;
`endif
        end else if (r_level == LEN_MAX) begin
          w_state_nx = S_WIN;
        end else begin
          w_state_nx = S_GEN;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // The entry being written in GEN is bypassed so SHOW displays it on its first cycle
  assign w_show_q = (w_wr_en && (w_idx_nx == r_level)) ? w_new_q : r_seq[w_idx_nx];

  // Output values for the upcoming state, registered below
  always_comb begin
    w_step_nx = 4'b0000;
    w_cuad_nx = 3'd0;
    w_busy_nx = 1'b0;
    w_win_nx  = 1'b0;
    w_lose_nx = 1'b0;
    case (w_state_nx)
      S_IDLE:  w_step_nx = 4'b0000;
      S_GEN:   begin w_step_nx = 4'b0001; w_busy_nx = 1'b1; end
      S_SHOW:  begin w_step_nx = 4'b0010; w_cuad_nx = w_show_q; w_busy_nx = 1'b1; end
      S_GAP:   begin w_step_nx = 4'b0001; w_busy_nx = 1'b1; end
      S_INPUT: begin w_step_nx = 4'b0011; w_busy_nx = 1'b1; end
      S_LOSE:  begin w_step_nx = 4'b0100; w_lose_nx = 1'b1; end
      S_WIN:   begin w_step_nx = 4'b0101; w_win_nx = 1'b1; end
      S_ECHO:  begin w_step_nx = 4'b0010; w_cuad_nx = w_echo_nx; w_busy_nx = 1'b1; end
      default: w_step_nx = 4'b0000;
    endcase
  end

  // State, pattern store and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_lfsr   <= LFSR_SEED;
      r_level  <= 4'd0;
      r_idx    <= 4'd0;
      r_frm    <= 8'd0;
      r_echo_q <= 3'd0;
      r_step   <= 4'b0000;
      r_cuad   <= 3'd0;
      r_busy   <= 1'b0;
      r_win    <= 1'b0;
      r_lose   <= 1'b0;
      for (int i = 0; i < 16; i++) r_seq[i] <= 3'd0;
    end else begin
      r_state  <= w_state_nx;
      r_lfsr   <= w_lfsr_nx;
      r_level  <= w_lvl_nx;
      r_idx    <= w_idx_nx;
      r_frm    <= w_frm_nx;
      r_echo_q <= w_echo_nx;
      r_step   <= w_step_nx;
      r_cuad   <= w_cuad_nx;
      r_busy   <= w_busy_nx;
      r_win    <= w_win_nx;
      r_lose   <= w_lose_nx;
      if (w_wr_en) r_seq[r_level] <= w_new_q;
    end
  end

  assign step      = r_step;
  assign cuadrante = r_cuad;
  assign level     = r_level;
  assign busy      = r_busy;
  assign win       = r_win;
  assign lose      = r_lose;

endmodule

// File: tb/tb_sprite_sequencer.sv
// Bench for sprite_sequencer: game-level reference model compared every cycle, plus directed literal checks.
module tb_sprite_sequencer;
  localparam int         SEQ_LEN = 2;
  localparam int         SHOW_F  = 2;
  localparam int         GAP_F   = 1;
  localparam logic [7:0] SEED    = 8'hA5;
  localparam int P_IDLE = 0, P_GEN = 1, P_SHOW = 2, P_GAP = 3, P_INPUT = 4, P_LOSE = 5, P_WIN = 6, P_ECHO = 7;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, frame_tick = 1'b0, btn_valid = 1'b0;
  logic [2:0] btn_quad = 3'd0;
  logic [3:0] step, level;
  logic [2:0] cuadrante;
  logic       busy, win, lose;

  int n_vec = 0, n_bad = 0;
  bit chk_en = 1'b0;

  // game-level model: phase, ticks remaining, position, pattern as a growing queue
  int         m_ph = P_IDLE, m_pos = 0, m_rem = 0, m_echo = 0;
  int         m_pat[$];
  logic [7:0] m_lfsr = SEED;

  always #5 clk = ~clk;

  sprite_sequencer #(.SEQ_LEN(SEQ_LEN), .SHOW_FRAMES(SHOW_F), .GAP_FRAMES(GAP_F), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick), .btn_valid(btn_valid),
    .btn_quad(btn_quad), .step(step), .cuadrante(cuadrante), .level(level),
    .busy(busy), .win(win), .lose(lose)
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  task automatic model_reset();
    m_ph = P_IDLE; m_pos = 0; m_rem = 0; m_echo = 0; m_lfsr = SEED;
    m_pat.delete();
  endtask

  task automatic model_edge();
    int nq;
    nq = (int'(m_lfsr) % 4) + 1;
    case (m_ph)
      P_IDLE, P_WIN, P_LOSE: if (start) begin m_ph = P_GEN; m_pat.delete(); end
      P_GEN: begin m_pat.push_back(nq); m_pos = 0; m_rem = SHOW_F; m_ph = P_SHOW; end
      P_SHOW: if (frame_tick) begin
        m_rem--;
        if (m_rem == 0) begin m_ph = P_GAP; m_rem = GAP_F; end
      end
      P_GAP: if (frame_tick) begin
        m_rem--;
        if (m_rem == 0) begin
          m_pos++;
          if (m_pos == m_pat.size()) begin m_ph = P_INPUT; m_pos = 0; end
          else begin m_ph = P_SHOW; m_rem = SHOW_F; end
        end
      end
      P_INPUT: if (btn_valid && btn_quad >= 3'd1 && btn_quad <= 3'd4) begin
        if (int'(btn_quad) != m_pat[m_pos]) m_ph = P_LOSE;
        else if (m_pos + 1 < m_pat.size()) begin
          m_pos++;
`ifdef SPRITE_SEQ_ECHO_EN
          m_ph = P_ECHO; m_echo = int'(btn_quad); m_rem = SHOW_F;
`endif
        end
        else if (m_pat.size() == SEQ_LEN) m_ph = P_WIN;
        else m_ph = P_GEN;
      end
      P_ECHO: if (frame_tick) begin
        m_rem--;
        if (m_rem == 0) m_ph = P_INPUT;
      end
      default: m_ph = P_IDLE;
    endcase
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_edge();
  end

  // per-cycle comparison against the model; step during the one-cycle GEN phase is not constrained
  always @(negedge clk) begin
    logic [3:0] es;
    int ec;
    bit eb;
    if (chk_en) begin
      case (m_ph)
        P_SHOW, P_ECHO: es = 4'b0010;
        P_GAP:          es = 4'b0001;
        P_INPUT:        es = 4'b0011;
        P_LOSE:         es = 4'b0100;
        P_WIN:          es = 4'b0101;
        default:        es = 4'b0000;
      endcase
      ec = (m_ph == P_SHOW) ? m_pat[m_pos] : ((m_ph == P_ECHO) ? m_echo : 0);
      eb = (m_ph == P_GEN) || (m_ph == P_SHOW) || (m_ph == P_GAP) || (m_ph == P_INPUT) || (m_ph == P_ECHO);
      n_vec++;
      if ((m_ph != P_GEN && step != es) || cuadrante != 3'(ec) || level != 4'(m_pat.size()) ||
          busy != eb || win != (m_ph == P_WIN) || lose != (m_ph == P_LOSE)) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t got step=%0d cuad=%0d lvl=%0d busy=%0d win=%0d lose=%0d want step=%0d cuad=%0d lvl=%0d busy=%0d phase=%0d",
                 $time, step, cuadrante, level, busy, win, lose, es, ec, m_pat.size(), eb, m_ph);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic press(input logic [2:0] q);
    btn_valid = 1'b1; btn_quad = q;
    cyc();
    btn_valid = 1'b0; btn_quad = 3'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic until_phase(input int ph, input int budget);
    int c;
    c = 0;
    while (m_ph != ph && c < budget) begin
      frame_tick = (c % 2 == 0);
      cyc();
      c++;
    end
    frame_tick = 1'b0;
    n_vec++;
    if (m_ph != ph) begin
      n_bad++;
      $display("FAIL reach_phase got=%0d want=%0d", m_ph, ph);
    end
  endtask

  initial begin
    int p, q0, q1;
    logic [7:0] v;
    lit("lfsr_a5", 32'(lfsr_step(8'hA5)), 32'h0000_00EA);
    lit("lfsr_ea", 32'(lfsr_step(8'hEA)), 32'h0000_0075);
    v = SEED; p = 0;
    do begin v = lfsr_step(v); p++; end while (v != SEED && p < 300);
    lit("lfsr_period", 32'(p), 32'd255);

    chk_en = 1'b1;
    repeat (3) cyc();
    lit("rst_outs", {step, cuadrante, level, busy, win, lose}, 32'd0);
    rst = 1'b0;
    repeat (3) cyc();

    // round 1: playback, ignored presses, then a wrong press
    pulse_start();
    cyc();
    lit("start_show", {step, level, busy}, {23'd0, 4'b0010, 4'd1, 1'b1});
    lit("start_cuad_rng", 32'(cuadrante >= 3'd1 && cuadrante <= 3'd4), 32'd1);
    until_phase(P_INPUT, 40);
    lit("input_step", 32'(step), 32'h3);
    press(3'd0);
    press(3'd5);
    lit("bad_btn_ignored", {lose, step}, {27'd0, 1'b0, 4'b0011});
    q0 = m_pat[0];
    press(3'((q0 % 4) + 1));
    lit("wrong_lose", {step, lose, busy}, {26'd0, 4'b0100, 1'b1, 1'b0});

    // round 2: correct presses to a win, start during SHOW ignored
    pulse_start();
    cyc();
    pulse_start();
    lit("start_in_show", {step, level}, {24'd0, 4'b0010, 4'd1});
    until_phase(P_INPUT, 40);
    q0 = m_pat[0];
    press(3'(q0));
    cyc();
    lit("r2_first_kept", {cuadrante, level}, {25'd0, 3'(q0), 4'd2});
    until_phase(P_INPUT, 60);
    press(3'(q0));
`ifdef SPRITE_SEQ_ECHO_EN
    lit("echo_show", {step, cuadrante}, {25'd0, 4'b0010, 3'(q0)});
    press(3'((q0 % 4) + 1));
    until_phase(P_INPUT, 20);
`else
    lit("no_echo", {step, cuadrante}, {25'd0, 4'b0011, 3'd0});
`endif
    q1 = m_pat[1];
    btn_valid = 1'b1; btn_quad = 3'(q1); frame_tick = 1'b1;
    cyc();
    btn_valid = 1'b0; btn_quad = 3'd0; frame_tick = 1'b0;
    lit("win", {step, win, level, busy}, {22'd0, 4'b0101, 1'b1, 4'd2, 1'b0});

    // async reset in the middle of SHOW, then a fresh game
    pulse_start();
    cyc();
    #2 rst = 1'b1;
    #1 lit("rst_async", {step, cuadrante, level, busy, win, lose}, 32'd0);
    cyc();
    rst = 1'b0;
    pulse_start();
    cyc();
    lit("after_rst", {level, step, busy}, {23'd0, 4'd1, 4'b0010, 1'b1});
    repeat (4) cyc();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
